// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA timing constants and the pattern enumeration for
//                the VGA test-pattern sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // 640x480@60 horizontal timing (pixels)
    localparam int c_h_active     = 640;
    localparam int c_h_fp         = 16;
    localparam int c_h_sync       = 96;
    localparam int c_h_bp         = 48;
    localparam int c_h_total      = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_h_sync_start = c_h_active + c_h_fp;
    localparam int c_h_sync_end   = c_h_sync_start + c_h_sync - 1;

    // 640x480@60 vertical timing (lines)
    localparam int c_v_active     = 480;
    localparam int c_v_fp         = 10;
    localparam int c_v_sync       = 2;
    localparam int c_v_bp         = 33;
    localparam int c_v_total      = c_v_active + c_v_fp + c_v_sync + c_v_bp;
    localparam int c_v_sync_start = c_v_active + c_v_fp;
    localparam int c_v_sync_end   = c_v_sync_start + c_v_sync - 1;

    // Frames each pattern stays on screen when auto-cycling
    localparam int c_frames_per_pattern = 120;

    // Counter width; both totals must fit in this many bits
    localparam int c_cnt_w = 10;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_WHITE    = 2'd3
    } pattern_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Horizontal/vertical raster counters with registered sync and
//                active-video flags, plus a combinational end-of-frame tick.
//                Counting freezes and the sync outputs go idle while i_ena=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ena,
    output logic [c_cnt_w-1:0] o_h,
    output logic [c_cnt_w-1:0] o_v,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_display_on,
    output logic               o_frame_tick
);

    localparam logic [c_cnt_w-1:0] c_h_vis   = c_cnt_w'(H_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_h_last  = c_cnt_w'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [c_cnt_w-1:0] c_hs_lo   = c_cnt_w'(H_ACTIVE + H_FP);
    localparam logic [c_cnt_w-1:0] c_hs_hi   = c_cnt_w'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_cnt_w-1:0] c_v_vis   = c_cnt_w'(V_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_v_last  = c_cnt_w'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [c_cnt_w-1:0] c_vs_lo   = c_cnt_w'(V_ACTIVE + V_FP);
    localparam logic [c_cnt_w-1:0] c_vs_hi   = c_cnt_w'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [c_cnt_w-1:0] r_h;
    logic [c_cnt_w-1:0] r_v;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_display_on;
    logic               w_h_last;
    logic               w_v_last;

    assign w_h_last = (r_h == c_h_last);
    assign w_v_last = (r_v == c_v_last);

    // Raster counters: h wraps every line, v steps on each h wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (i_ena) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Sync and active-video flags, registered so they align with the colour pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_display_on <= 1'b0;
        end else if (!i_ena) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_display_on <= 1'b0;
        end else begin
            r_hsync      <= !((r_h >= c_hs_lo) && (r_h <= c_hs_hi));
            r_vsync      <= !((r_v >= c_vs_lo) && (r_v <= c_vs_hi));
            r_display_on <= (r_h < c_h_vis) && (r_v < c_v_vis);
        end
    end

    assign o_h          = r_h;
    assign o_v          = r_v;
    assign o_hsync      = r_hsync;
    assign o_vsync      = r_vsync;
    assign o_display_on = r_display_on;
    // Frame boundary is the last pixel of the last line; suppressed while frozen
    assign o_frame_tick = i_ena & w_h_last & w_v_last;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_sequencer
//  Description : VGA test-pattern controller. Generates raster timing, picks
//                one of four patterns and steps the pattern only on frame
//                boundaries, either from a synchronised button edge or, when
//                built with AUTO_CYCLE_EN defined, automatically every
//                FRAMES_PER_PATTERN frames.
//  Build macro : AUTO_CYCLE_EN - enables the auto-cycle frame counter
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_sequencer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE           = c_h_active,
    parameter int H_FP               = c_h_fp,
    parameter int H_SYNC             = c_h_sync,
    parameter int H_BP               = c_h_bp,
    parameter int V_ACTIVE           = c_v_active,
    parameter int V_FP               = c_v_fp,
    parameter int V_SYNC             = c_v_sync,
    parameter int V_BP               = c_v_bp,
    parameter int FRAMES_PER_PATTERN = c_frames_per_pattern
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       advance_i,
    input  logic       pause_i,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       display_on,
    output logic [1:0] pattern_o,
    output logic       frame_tick
);

    localparam logic [c_cnt_w-1:0] c_h_vis = c_cnt_w'(H_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_v_vis = c_cnt_w'(V_ACTIVE);

    logic [c_cnt_w-1:0] w_h;
    logic [c_cnt_w-1:0] w_v;
    logic               w_frame_tick;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .i_ena        (ena),
        .o_h          (w_h),
        .o_v          (w_v),
        .o_hsync      (hsync),
        .o_vsync      (vsync),
        .o_display_on (display_on),
        .o_frame_tick (w_frame_tick)
    );

    assign frame_tick = w_frame_tick;

    // ------------------------------------------------------------------------
    // Button path: two-flop synchroniser, edge detect, sticky pending request
    // ------------------------------------------------------------------------
    logic r_adv_meta;
    logic r_adv_sync;
    logic r_adv_last;
    logic w_adv_edge;
    logic r_pending;
    logic w_auto_term;
    logic w_advance;

    // Synchronise the asynchronous button and keep one extra stage for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adv_meta <= 1'b0;
            r_adv_sync <= 1'b0;
            r_adv_last <= 1'b0;
        end else begin
            r_adv_meta <= advance_i;
            r_adv_sync <= r_adv_meta;
            r_adv_last <= r_adv_sync;
        end
    end

    assign w_adv_edge = r_adv_sync & ~r_adv_last;

    // A single step consumes the request; an edge landing on that same cycle survives
    assign w_advance = w_frame_tick & (r_pending | w_auto_term);

    // Pending request collapses any number of presses within one frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_adv_edge | (r_pending & ~w_advance);
        end
    end

    // ------------------------------------------------------------------------
    // Auto-cycle frame counter
    // ------------------------------------------------------------------------
`ifdef AUTO_CYCLE_EN
    localparam int                  c_fc_w    = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [c_fc_w-1:0]   c_fc_last = c_fc_w'(FRAMES_PER_PATTERN - 1);

    logic [c_fc_w-1:0] r_frame_cnt;

    assign w_auto_term = (r_frame_cnt == c_fc_last) & ~pause_i;

    // Count shown frames; any pattern step restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            if (w_advance) begin
                r_frame_cnt <= '0;
            end else if (!pause_i) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_pause;

    assign w_auto_term    = 1'b0;
    assign w_unused_pause = pause_i;
`endif

    // ------------------------------------------------------------------------
    // Pattern FSM: one step per frame boundary at most, wrapping 3 -> 0
    // ------------------------------------------------------------------------
    pattern_t r_pattern;
    pattern_t w_pattern_next;

    // Pattern state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= PAT_BARS;
        end else begin
            r_pattern <= w_pattern_next;
        end
    end

    // Next pattern: hold unless a frame-boundary advance is granted
    always_comb begin
        w_pattern_next = r_pattern;
        if (w_advance) begin
            case (r_pattern)
                PAT_BARS:     w_pattern_next = PAT_CHECKER;
                PAT_CHECKER:  w_pattern_next = PAT_GRADIENT;
                PAT_GRADIENT: w_pattern_next = PAT_WHITE;
                PAT_WHITE:    w_pattern_next = PAT_BARS;
                default:      w_pattern_next = PAT_BARS;
            endcase
        end
    end

    assign pattern_o = r_pattern;

    // ------------------------------------------------------------------------
    // Colour generation and output registers
    // ------------------------------------------------------------------------
    logic [2:0] w_idx;
    logic [1:0] w_red;
    logic [1:0] w_grn;
    logic [1:0] w_blu;
    logic [1:0] r_red;
    logic [1:0] r_grn;
    logic [1:0] r_blu;

    assign w_idx = w_h[8:6];

    // Colour for the current raster position; black outside the visible area
    always_comb begin
        w_red = 2'b00;
        w_grn = 2'b00;
        w_blu = 2'b00;
        if ((w_h < c_h_vis) && (w_v < c_v_vis)) begin
            case (r_pattern)
                PAT_BARS: begin
                    w_red = {2{w_idx[2]}};
                    w_grn = {2{w_idx[1]}};
                    w_blu = {2{w_idx[0]}};
                end
                PAT_CHECKER: begin
                    w_red = {2{w_h[5] ^ w_v[5]}};
                    w_grn = {2{w_h[5] ^ w_v[5]}};
                    w_blu = {2{w_h[5] ^ w_v[5]}};
                end
                PAT_GRADIENT: begin
                    w_red = w_h[7:6];
                    w_grn = w_v[7:6];
                    w_blu = w_h[9:8];
                end
                PAT_WHITE: begin
                    w_red = 2'b11;
                    w_grn = 2'b11;
                    w_blu = 2'b11;
                end
                default: begin
                    w_red = 2'b00;
                    w_grn = 2'b00;
                    w_blu = 2'b00;
                end
            endcase
        end
    end

    // Register the colour pins so they line up with the registered sync outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red <= 2'b00;
            r_grn <= 2'b00;
            r_blu <= 2'b00;
        end else if (!ena) begin
            r_red <= 2'b00;
            r_grn <= 2'b00;
            r_blu <= 2'b00;
        end else begin
            r_red <= w_red;
            r_grn <= w_grn;
            r_blu <= w_blu;
        end
    end

    assign r = r_red;
    assign g = r_grn;
    assign b = r_blu;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pattern_sequencer
//  Description : Self-checking bench for vga_pattern_sequencer using reduced
//                raster timing. Every cycle the expected pin values for the
//                current raster position are queued, then compared one clock
//                later; directed steps set the expected pattern per frame.
//                Auto-cycle expectations are used when AUTO_CYCLE_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_sequencer;

    localparam int HA  = 256;
    localparam int HF  = 8;
    localparam int HS  = 16;
    localparam int HB  = 8;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VA  = 4;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FPP = 2;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       advance_i;
    logic       pause_i;
    logic       hsync;
    logic       vsync;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       display_on;
    logic [1:0] pattern_o;
    logic       frame_tick;

    vga_pattern_sequencer #(
        .H_ACTIVE           (HA),
        .H_FP               (HF),
        .H_SYNC             (HS),
        .H_BP               (HB),
        .V_ACTIVE           (VA),
        .V_FP               (VF),
        .V_SYNC             (VS),
        .V_BP               (VB),
        .FRAMES_PER_PATTERN (FPP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .advance_i  (advance_i),
        .pause_i    (pause_i),
        .hsync      (hsync),
        .vsync      (vsync),
        .r          (r),
        .g          (g),
        .b          (b),
        .display_on (display_on),
        .pattern_o  (pattern_o),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [1:0] rr;
        logic [1:0] gg;
        logic [1:0] bb;
        logic       de;
    } px_t;

    px_t        sb[$];
    int         checks;
    int         errors;
    int         mh;
    int         mv;
    logic [1:0] m_pat;
    logic [1:0] m_pat_next;
    int         hs_run;
    int         vs_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected pins for a raster position, written from the pattern definitions
    function automatic px_t predict(input int h, input int v, input logic [1:0] pat, input logic en);
        px_t p;
        int  idx;
        p    = '0;
        p.hs = 1'b1;
        p.vs = 1'b1;
        idx  = (h / 64) % 8;
        if (en) begin
            p.hs = !(h >= HA + HF && h < HA + HF + HS);
            p.vs = !(v >= VA + VF && v < VA + VF + VS);
            if (h < HA && v < VA) begin
                p.de = 1'b1;
                case (pat)
                    2'd0: begin
                        p.rr = (idx >= 4) ? 2'd3 : 2'd0;
                        p.gg = (((idx / 2) % 2) == 1) ? 2'd3 : 2'd0;
                        p.bb = ((idx % 2) == 1) ? 2'd3 : 2'd0;
                    end
                    2'd1: begin
                        if (((h / 32) % 2) != ((v / 32) % 2)) begin
                            p.rr = 2'd3;
                            p.gg = 2'd3;
                            p.bb = 2'd3;
                        end
                    end
                    2'd2: begin
                        p.rr = 2'((h / 64) % 4);
                        p.gg = 2'((v / 64) % 4);
                        p.bb = 2'((h / 256) % 4);
                    end
                    default: begin
                        p.rr = 2'd3;
                        p.gg = 2'd3;
                        p.bb = 2'd3;
                    end
                endcase
            end
        end
        return p;
    endfunction

    // One clock: queue expectation, clock, advance the model, compare
    task automatic tick();
        px_t  e;
        px_t  got;
        logic en;
        en = ena;
        sb.push_back(predict(mh, mv, m_pat, en));
        @(posedge clk);
        #1;
        if (en) begin
            if (mh == HT - 1 && mv == VT - 1) m_pat = m_pat_next;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        got = {hsync, vsync, r, g, b, display_on};
        e   = sb.pop_front();
        chk("pixel", 32'(got), 32'(e));
        chk("pattern_o", 32'(pattern_o), 32'(m_pat));
        chk("frame_tick", 32'(frame_tick), 32'(en && mh == HT - 1 && mv == VT - 1));
        if (!hsync) hs_run++;
        else begin
            if (hs_run != 0) chk("hsync_width", 32'(hs_run), 32'(HS));
            hs_run = 0;
        end
        if (!vsync) vs_run++;
        else begin
            if (vs_run != 0) chk("vsync_width", 32'(vs_run), 32'(VS * HT));
            vs_run = 0;
        end
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (mh == h && mv == v) break;
            tick();
        end
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(mh == 0 && mv == 0) && n < 2 * HT * VT);
    endtask

    task automatic press();
        advance_i = 1'b1;
        repeat (3) tick();
        advance_i = 1'b0;
        repeat (3) tick();
    endtask

    task automatic model_reset();
        mh         = 0;
        mv         = 0;
        m_pat      = 2'd0;
        m_pat_next = 2'd0;
        hs_run     = 0;
        vs_run     = 0;
        sb.delete();
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        ena       = 1'b1;
        advance_i = 1'b0;
        pause_i   = 1'b1;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_g", 32'(g), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_display_on", 32'(display_on), 32'd0);
        chk("rst_pattern", 32'(pattern_o), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;

        // One full frame, then frame_tick period
        finish_frame();
        run_to(HT - 1, VT - 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 2 * HT * VT);
        chk("frame_tick_period", 32'(n), 32'(HT * VT));

        // Bars pixel at h=200 (idx=3) and a blanked pixel in the porch
        run_to(200, 2);
        tick();
        chk("bars_h200_r", 32'(r), 32'd0);
        chk("bars_h200_g", 32'(g), 32'd3);
        chk("bars_h200_b", 32'(b), 32'd3);
        chk("bars_h200_de", 32'(display_on), 32'd1);
        run_to(HA + HF + HS + 2, 2);
        tick();
        chk("porch_rgb", 32'({r, g, b}), 32'd0);
        chk("porch_de", 32'(display_on), 32'd0);

        // Three presses in one frame give a single step at the boundary
        press();
        press();
        press();
        m_pat_next = 2'd1;
        finish_frame();
        chk("step_at_boundary", 32'(pattern_o), 32'd1);
        finish_frame();
        chk("single_advance", 32'(pattern_o), 32'd1);

        // Edge arriving on the frame_tick cycle waits for the next boundary
        run_to(HT - 3, VT - 1);
        advance_i = 1'b1;
        repeat (4) tick();
        advance_i = 1'b0;
        chk("tick_edge_deferred", 32'(pattern_o), 32'd1);
        m_pat_next = 2'd2;
        finish_frame();
        chk("tick_edge_applied", 32'(pattern_o), 32'd2);

        // Enable low for 1000 clocks: blank, frozen, button still registers
        run_to(100, 2);
        ena = 1'b0;
        tick();
        chk("ena_hsync", 32'(hsync), 32'd1);
        chk("ena_rgb", 32'({r, g, b}), 32'd0);
        chk("ena_de", 32'(display_on), 32'd0);
        press();
        repeat (1000 - 7) tick();
        ena = 1'b1;
        m_pat_next = 2'd3;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 2 * HT * VT);
        chk("resume_position", 32'(n), 32'((VT - 3) * HT + (HT - 1 - 100)));
        tick();
        chk("ena_pending_advance", 32'(pattern_o), 32'd3);

        // Asynchronous reset mid-frame clears outputs at once
        run_to(100, 3);
        rst = 1'b1;
        #1;
        chk("midrst_hsync", 32'(hsync), 32'd1);
        chk("midrst_vsync", 32'(vsync), 32'd1);
        chk("midrst_rgb", 32'({r, g, b}), 32'd0);
        chk("midrst_pattern", 32'(pattern_o), 32'd0);
        chk("midrst_de", 32'(display_on), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

`ifdef AUTO_CYCLE_EN
        // Auto cycling: a step every FPP frames, wrapping to 0
        pause_i = 1'b0;
        for (int f = 0; f < 8; f++) begin
            m_pat_next = ((f % FPP) == FPP - 1) ? 2'(m_pat + 2'd1) : m_pat;
            finish_frame();
        end
        chk("auto_wrap", 32'(pattern_o), 32'd0);
        pause_i    = 1'b1;
        m_pat_next = m_pat;
        repeat (3) finish_frame();
        chk("pause_hold", 32'(pattern_o), 32'd0);
        // Button in the auto-terminal frame: one step, counter restarts
        pause_i = 1'b0;
        finish_frame();
        press();
        m_pat_next = 2'd1;
        finish_frame();
        chk("auto_button_single", 32'(pattern_o), 32'd1);
        finish_frame();
        chk("auto_cnt_restart", 32'(pattern_o), 32'd1);
        m_pat_next = 2'd2;
        finish_frame();
        chk("auto_after_restart", 32'(pattern_o), 32'd2);
`else
        // Without auto cycling the pattern only moves on a button press
        pause_i = 1'b0;
        repeat (3) finish_frame();
        chk("no_auto_hold", 32'(pattern_o), 32'd0);
        pause_i = 1'b1;
        press();
        m_pat_next = 2'd1;
        finish_frame();
        chk("button_with_pause", 32'(pattern_o), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
